// File: rtl/bch_encode_serial.sv
// Serial systematic binary BCH encoder.
// Message bits pass straight through to dout, one per accepted cycle.
// A generator-polynomial LFSR accumulates the remainder, and the P parity
// bits are then shifted out MSB-first behind the K data bits. Both sides
// use valid/ready handshakes around a one-entry output register.
module bch_encode_serial #(
    parameter int M = 4,
    parameter int K = 5,
    parameter int P = 10,
    parameter logic [P-1:0] GEN = 10'h137
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    output logic dout,
    output logic dout_valid,
    input  logic dout_ready,
    output logic dout_first,
    output logic dout_last,
    output logic busy
);

    localparam int CNT_MAX = (K > P) ? K : P;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] K_LAST = CW'(K - 1);
    localparam logic [CW-1:0] P_LAST = CW'(P - 1);

    // The code needs at least one data bit, a generator of degree two or
    // more with a constant term, and a codeword that fits in 2^M-1 bits.
    if (K < 1 || P < 2 || GEN[0] != 1'b1 || (K + P) > ((2 ** M) - 1)) begin : g_bad_params
        $fatal(1, "bch_encode_serial: illegal parameter set");
    end

    typedef enum logic {
        S_DATA,
        S_PARITY
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [P-1:0]  lfsr, lfsr_nx;

    logic slot_free;
    logic accept;
    logic fb;
    logic slot_load;
    logic slot_bit;
    logic slot_first;
    logic slot_last;

    assign slot_free = !dout_valid || dout_ready;
    assign din_ready = (state == S_DATA) && slot_free;
    assign accept    = din_valid && din_ready;
    assign fb        = din ^ lfsr[P-1];
    assign busy      = (state == S_PARITY) || (cnt != '0);

    // Next-state, counter, remainder and output-slot load decisions.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        lfsr_nx    = lfsr;
        slot_load  = 1'b0;
        slot_bit   = 1'b0;
        slot_first = 1'b0;
        slot_last  = 1'b0;
        case (state)
            S_DATA: begin
                if (accept) begin
                    slot_load  = 1'b1;
                    slot_bit   = din;
                    slot_first = (cnt == '0);
                    lfsr_nx    = {lfsr[P-2:0], 1'b0} ^ (fb ? GEN : '0);
                    if (cnt == K_LAST) begin
                        cnt_nx   = '0;
                        state_nx = S_PARITY;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                // The remainder sits MSB-aligned in the LFSR; shifting it
                // out with zero feedback emits the parity bits in order.
                if (slot_free) begin
                    slot_load = 1'b1;
                    slot_bit  = lfsr[P-1];
                    slot_last = (cnt == P_LAST);
                    lfsr_nx   = {lfsr[P-2:0], 1'b0};
                    if (cnt == P_LAST) begin
                        cnt_nx   = '0;
                        lfsr_nx  = '0;
                        state_nx = S_DATA;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_DATA;
            end
        endcase
    end

    // Control state, bit counter and remainder register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_DATA;
            cnt   <= '0;
            lfsr  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            lfsr  <= lfsr_nx;
        end
    end

    // One-entry output slot: reload wins over a take in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
        end else if (slot_load) begin
            dout       <= slot_bit;
            dout_valid <= 1'b1;
            dout_first <= slot_first;
            dout_last  <= slot_last;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule
